// File: rtl/mp_add_pkg.sv
// Shared types and helpers for the multi-precision add sequencer.
package mp_add_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Slice index width; a single-slice operand still needs a 1-bit index.
    function automatic int unsigned idx_width(input int unsigned w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/rca_Nbit_co.sv
// N-bit ripple-carry adder with carry in/out; the shared slice adder.
module rca_Nbit_co #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic         i_ci,
    output logic [N-1:0] o_s,
    output logic         o_co
);

    logic [N:0] w_c;

    assign w_c[0] = i_ci;

    for (genvar g = 0; g < N; g++) begin : g_fa
        assign o_s[g]     = i_a[g] ^ i_b[g] ^ w_c[g];
        assign w_c[g + 1] = (i_a[g] & i_b[g]) | (w_c[g] & (i_a[g] ^ i_b[g]));
    end

    assign o_co = w_c[N];

endmodule

// File: rtl/mp_add_seq.sv
// Multi-precision add sequencer: one N-bit adder reused over W slices, LSB slice first.
module mp_add_seq
    import mp_add_pkg::*;
#(
    parameter int unsigned N = 4,
    parameter int unsigned W = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N*W-1:0] a_in,
    input  logic [N*W-1:0] b_in,
    input  logic           cin,
    output logic           ready,
    output logic           busy,
    output logic           done,
    output logic [N*W-1:0] sum_out,
    output logic           cout,
    output logic           ovf
);

    localparam int unsigned   IW   = idx_width(W);
    localparam int unsigned   NW   = N * W;
    localparam logic [IW-1:0] LAST = IW'(W - 1);

    state_t          r_state, w_state_nxt;
    logic [IW-1:0]   r_idx;
    logic [NW-1:0]   r_a, r_b, r_part, r_sum;
    logic            r_carry, r_cout, r_ovf;

    logic [N-1:0]    w_a_sl, w_b_sl, w_s_sl;
    logic            w_co, w_accept, w_last;
    logic [NW-1:0]   w_full;

    assign w_a_sl = r_a[r_idx * N +: N];
    assign w_b_sl = r_b[r_idx * N +: N];
    assign w_last = (r_idx == LAST);

    rca_Nbit_co #(.N(N)) u_rca (
        .i_a  (w_a_sl),
        .i_b  (w_b_sl),
        .i_ci (r_carry),
        .o_s  (w_s_sl),
        .o_co (w_co)
    );

    // Partial sum with the current slice merged in, so the final slice lands in sum_out directly.
    always_comb begin
        w_full                 = r_part;
        w_full[r_idx * N +: N] = w_s_sl;
    end

    always_comb begin
        w_state_nxt = r_state;
        ready       = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                ready = 1'b1;
                if (start) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                busy = 1'b1;
                if (w_last) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                ready       = 1'b1;
                done        = 1'b1;
                w_state_nxt = start ? ST_RUN : ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_accept = ready & start;

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idx   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_part  <= '0;
            r_carry <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_a     <= a_in;
            r_b     <= b_in;
            r_part  <= '0;
            r_carry <= cin;
            r_idx   <= '0;
        end else if (r_state == ST_RUN) begin
            r_part  <= w_full;
            r_carry <= w_co;
            if (w_last) begin
                r_idx  <= '0;
                r_sum  <= w_full;
                r_cout <= w_co;
                r_ovf  <= (r_a[NW-1] == r_b[NW-1]) && (w_full[NW-1] != r_a[NW-1]);
            end else begin
                r_idx  <= r_idx + 1'b1;
            end
        end
    end

    assign sum_out = r_sum;
    assign cout    = r_cout;
    assign ovf     = r_ovf;

endmodule
